// File: rtl/pc_seq_pkg.sv
// Shared types and default parameters for the fetch-address sequencer.
package pc_seq_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      PEND   = 2'd1,
      HALTED = 2'd2
   } pc_state_t;

   localparam int          ADDR_W_DEF    = 64;
   localparam int          INC_DEF       = 4;
   localparam logic [63:0] RESET_VEC_DEF = 64'h0000_0000_0000_0000;
   localparam logic [63:0] EXC_VEC_DEF   = 64'h0000_0000_0000_0100;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/observation bundle between branch/hazard logic (master) and the sequencer (slave).
interface pc_sequencer_if #(
   parameter int ADDR_W = 64
);
   logic              stall;
   logic              br_taken;
   logic [ADDR_W-1:0] br_target;
   logic              exc;
   logic              halt;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_next_seq;
   logic [ADDR_W-1:0] pc_dec;
   logic              dec_valid;
   logic              redirect_pending;
   logic              halted;

   modport master (
      output stall, br_taken, br_target, exc, halt,
      input  pc, pc_next_seq, pc_dec, dec_valid, redirect_pending, halted
   );

   modport slave (
      input  stall, br_taken, br_target, exc, halt,
      output pc, pc_next_seq, pc_dec, dec_valid, redirect_pending, halted
   );
endinterface

// File: rtl/pc_reg.sv
// Address-wide register with asynchronous active-high reset to a parameterised value and load enable.
module pc_reg #(
   parameter int           W       = 64,
   parameter logic [W-1:0] RST_VAL = {W{1'b0}}
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   // Storage: loads d_i only when enabled
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_o <= RST_VAL;
      end else if (en_i) begin
         q_o <= d_i;
      end else begin
         q_o <= q_o;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: sequential advance, stall, immediate/deferred redirect,
// exception vectoring, sticky halt and a one-stage decode PC register.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int                ADDR_W    = ADDR_W_DEF,
   parameter int                INC       = INC_DEF,
   parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEF),
   parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(EXC_VEC_DEF)
) (
   input  logic            clk,
   input  logic            reset,
   pc_sequencer_if.slave   bus
);

   localparam logic [ADDR_W-1:0] INC_V = ADDR_W'(INC);

   pc_state_t         state_q, state_d;
   logic              dv_q, dv_d;
   logic [ADDR_W-1:0] pc_q, pc_d, pend_q, dec_q;
   logic              pc_en, pend_en, dec_en;

   pc_reg #(.W(ADDR_W), .RST_VAL(RESET_VEC)) u_pc (
      .clk(clk), .reset(reset), .en_i(pc_en), .d_i(pc_d), .q_o(pc_q)
   );

   pc_reg #(.W(ADDR_W), .RST_VAL({ADDR_W{1'b0}})) u_pend (
      .clk(clk), .reset(reset), .en_i(pend_en), .d_i(bus.br_target), .q_o(pend_q)
   );

   pc_reg #(.W(ADDR_W), .RST_VAL({ADDR_W{1'b0}})) u_dec (
      .clk(clk), .reset(reset), .en_i(dec_en), .d_i(pc_q), .q_o(dec_q)
   );

   // Priority chain: exception, halted hold, halt, redirect, defer, replay, stall, advance
   always_comb begin
      state_d = state_q;
      dv_d    = dv_q;
      pc_d    = pc_q;
      pc_en   = 1'b0;
      pend_en = 1'b0;
      dec_en  = 1'b0;
      if (bus.exc) begin
         pc_en   = 1'b1;
         pc_d    = EXC_VEC;
         dv_d    = 1'b0;
         state_d = RUN;
      end else if (state_q == HALTED) begin
         state_d = HALTED;
      end else if (bus.halt) begin
         dv_d    = 1'b0;
         state_d = HALTED;
      end else if (bus.br_taken && !bus.stall) begin
         pc_en   = 1'b1;
         pc_d    = bus.br_target;
         dv_d    = 1'b0;
         state_d = RUN;
      end else if (bus.br_taken) begin
         pend_en = 1'b1;
         state_d = PEND;
      end else if ((state_q == PEND) && !bus.stall) begin
         pc_en   = 1'b1;
         pc_d    = pend_q;
         dv_d    = 1'b0;
         state_d = RUN;
      end else if (bus.stall) begin
         state_d = state_q;
      end else begin
         pc_en   = 1'b1;
         pc_d    = pc_q + INC_V;
         dec_en  = 1'b1;
         dv_d    = 1'b1;
         state_d = RUN;
      end
   end

   // State and decode-valid registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= RUN;
         dv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         dv_q    <= dv_d;
      end
   end

   assign bus.pc               = pc_q;
   assign bus.pc_next_seq      = pc_q + INC_V;
   assign bus.pc_dec           = dec_q;
   assign bus.dec_valid        = dv_q;
   assign bus.redirect_pending = (state_q == PEND);
   assign bus.halted           = (state_q == HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench: one stimulus stream drives a 64-bit and an 8-bit sequencer,
// a rule-level reference model predicts both, and a monitor compares each cycle.
module tb_pc_sequencer;

   typedef struct {
      logic [63:0] pc;
      logic [63:0] dec;
      logic [63:0] pend;
      bit          dv;
      bit          pendv;
      bit          halted;
   } ms_t;

   typedef struct {
      ms_t w64;
      ms_t w8;
   } exp_t;

   localparam logic [63:0] M64 = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] M8  = 64'h0000_0000_0000_00FF;
   localparam logic [63:0] EXC = 64'h0000_0000_0000_0100;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pc_sequencer_if #(.ADDR_W(64)) if64 ();
   pc_sequencer_if #(.ADDR_W(8))  if8 ();

   assign if8.stall     = if64.stall;
   assign if8.br_taken  = if64.br_taken;
   assign if8.br_target = if64.br_target[7:0];
   assign if8.exc       = if64.exc;
   assign if8.halt      = if64.halt;

   pc_sequencer #(.ADDR_W(64), .INC(4), .RESET_VEC(64'h0), .EXC_VEC(64'h100)) u_dut64 (
      .clk(clk), .reset(reset), .bus(if64.slave)
   );

   pc_sequencer #(.ADDR_W(8), .INC(4), .RESET_VEC(8'h00), .EXC_VEC(8'h00)) u_dut8 (
      .clk(clk), .reset(reset), .bus(if8.slave)
   );

   ms_t  m64, m8;
   exp_t q[$];
   exp_t e;
   int   n_vec = 0;
   int   n_mis = 0;

   function automatic ms_t m_reset();
      ms_t s;
      s.pc = 64'h0; s.dec = 64'h0; s.pend = 64'h0;
      s.dv = 1'b0; s.pendv = 1'b0; s.halted = 1'b0;
      return s;
   endfunction

   // One clock edge of the sequencer described as prioritised rules
   function automatic ms_t step(ms_t s, bit st, bit br, logic [63:0] tgt,
                                bit ex, bit hl, logic [63:0] mask);
      ms_t n;
      n = s;
      if (ex) begin
         n.pc = EXC & mask; n.dv = 1'b0; n.pendv = 1'b0; n.halted = 1'b0;
      end else if (s.halted) begin
         n = s;
      end else if (hl) begin
         n.halted = 1'b1; n.dv = 1'b0; n.pendv = 1'b0;
      end else if (br && !st) begin
         n.pc = tgt & mask; n.dv = 1'b0; n.pendv = 1'b0;
      end else if (br) begin
         n.pend = tgt & mask; n.pendv = 1'b1;
      end else if (s.pendv && !st) begin
         n.pc = s.pend; n.dv = 1'b0; n.pendv = 1'b0;
      end else if (!st) begin
         n.dec = s.pc; n.dv = 1'b1; n.pc = (s.pc + 64'd4) & mask;
      end
      return n;
   endfunction

   task automatic push_exp();
      exp_t x;
      x.w64 = m64;
      x.w8  = m8;
      q.push_back(x);
   endtask

   task automatic cyc(bit st, bit br, logic [63:0] tgt, bit ex, bit hl);
      if64.stall = st; if64.br_taken = br; if64.br_target = tgt;
      if64.exc = ex; if64.halt = hl;
      m64 = step(m64, st, br, tgt, ex, hl, M64);
      m8  = step(m8,  st, br, tgt, ex, hl, M8);
      @(posedge clk);
      #1;
      push_exp();
   endtask

   task automatic free(int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
   endtask

   // Reset asserted just after an edge; checked before the following edge
   task automatic async_rst();
      @(posedge clk);
      #1;
      reset = 1'b1;
      m64 = m_reset(); m8 = m_reset();
      push_exp();
      if64.stall = 1'b0; if64.br_taken = 1'b0; if64.exc = 1'b0; if64.halt = 1'b0;
      @(posedge clk);
      #1;
      push_exp();
      #1;
      reset = 1'b0;
   endtask

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // Monitor: pops one expectation per cycle, between edges
   always @(posedge clk) begin
      #3;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("pc64",     if64.pc,                        e.w64.pc);
         chk("nseq64",   if64.pc_next_seq,               (e.w64.pc + 64'd4) & M64);
         chk("dec64",    if64.pc_dec,                    e.w64.dec);
         chk("dv64",     {63'h0, if64.dec_valid},        {63'h0, e.w64.dv});
         chk("rp64",     {63'h0, if64.redirect_pending}, {63'h0, e.w64.pendv});
         chk("halt64",   {63'h0, if64.halted},           {63'h0, e.w64.halted});
         chk("pc8",      {56'h0, if8.pc},                e.w8.pc);
         chk("nseq8",    {56'h0, if8.pc_next_seq},       (e.w8.pc + 64'd4) & M8);
         chk("dec8",     {56'h0, if8.pc_dec},            e.w8.dec);
         chk("dv8",      {63'h0, if8.dec_valid},         {63'h0, e.w8.dv});
         chk("rp8",      {63'h0, if8.redirect_pending},  {63'h0, e.w8.pendv});
         chk("halt8",    {63'h0, if8.halted},            {63'h0, e.w8.halted});
      end
   end

   initial begin
      reset = 1'b1;
      if64.stall = 1'b0; if64.br_taken = 1'b0; if64.br_target = 64'h0;
      if64.exc = 1'b0; if64.halt = 1'b0;
      m64 = m_reset(); m8 = m_reset();
      repeat (2) begin
         @(posedge clk);
         #1;
         push_exp();
      end
      reset = 1'b0;

      // Advance from reset, then run the 8-bit copy through its wrap
      free(3);
      free(62);

      // Deferred redirect: newest target wins, lands when stall drops
      async_rst();
      free(4);
      cyc(1'b1, 1'b1, 64'h200, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 64'h300, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 64'h0,   1'b0, 1'b0);
      free(2);

      // Exception from HALTED overrides stall and halt
      async_rst();
      free(16);
      cyc(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 64'h0, 1'b1, 1'b1);
      free(1);

      // Simultaneous events
      cyc(1'b0, 1'b1, 64'h80, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 64'h0,  1'b0, 1'b0);
      cyc(1'b0, 1'b1, 64'h80, 1'b1, 1'b0);
      free(1);

      // Async reset while a redirect is pending
      cyc(1'b1, 1'b1, 64'h240, 1'b0, 1'b0);
      async_rst();
      free(1);

      // 64-bit wrap
      cyc(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b0);
      free(3);

      // Randomised traffic
      for (int i = 0; i < 400; i++) begin
         logic [63:0] t;
         t = {$urandom, $urandom};
         if (($urandom % 8) == 0) t = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom % 16);
         cyc(($urandom % 10) < 4, ($urandom % 4) == 0, t,
             ($urandom % 40) == 0, ($urandom % 60) == 0);
      end

      for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
      #5;
      if (q.size() > 0) begin
         n_mis++;
         $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
